// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on load, per-round C/D rotation, PC-2 on output; one subkey per handshake.
// Optional key parity check enabled by defining DES_KS_PARITY_CHK_EN.
module des_key_schedule #(
  parameter int                    NUM_ROUNDS  = 16,
  parameter logic [NUM_ROUNDS-1:0] SHIFT_SCHED = 16'h7EFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk_data,
  output logic [4:0]  sk_round,
  output logic        sk_last,
  output logic        parity_err
);

  localparam int RW = $clog2(NUM_ROUNDS + 1);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE, RUN} state_t;

  // Table positions are DES bit numbers, 1 = MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] p;
    for (int i = 0; i < 56; i++) p[55-i] = k[64-PC1_TAB[i]];
    return p;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] p;
    for (int i = 0; i < 48; i++) p[47-i] = cd[56-PC2_TAB[i]];
    return p;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input logic right, input logic two);
    case ({right, two})
      2'b00:   return {h[26:0], h[27]};
      2'b01:   return {h[25:0], h[27:26]};
      2'b10:   return {h[0], h[27:1]};
      default: return {h[1:0], h[27:2]};
    endcase
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right, input logic two);
    return {rot28(cd[55:28], right, two), rot28(cd[27:0], right, two)};
  endfunction

  state_t          state_q, state_d;
  logic [55:0]     cd_q, cd_d;
  logic [RW-1:0]   round_q, round_d;
  logic            dec_q, dec_d;
  logic            load;
  logic            last;
  logic [RW-1:0]   sched_idx;
  logic            shift_two;

  assign last = (round_q == RW'(NUM_ROUNDS));

  // Decrypt walks the schedule backwards, so it undoes the shift of the round it leaves.
  assign sched_idx = dec_q ? (RW'(NUM_ROUNDS) - round_q) : round_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_two = 1'b0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (RW'(i) == sched_idx) shift_two = SHIFT_SCHED[i];
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    round_d   = round_q;
    dec_d     = dec_q;
    load      = 1'b0;
    key_ready = 1'b0;
    sk_valid  = 1'b0;
    sk_data   = '0;
    sk_round  = '0;
    sk_last   = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load    = 1'b1;
          state_d = RUN;
          dec_d   = decrypt;
          round_d = RW'(1);
          cd_d    = decrypt ? pc1(key) : rot_cd(pc1(key), 1'b0, SHIFT_SCHED[0]);
        end
      end
      RUN: begin
        sk_valid = 1'b1;
        sk_data  = pc2(cd_q);
        sk_round = 5'(round_q);
        sk_last  = last;
        if (sk_ready) begin
          if (last) begin
            state_d = IDLE;
            round_d = '0;
          end else begin
            cd_d    = rot_cd(cd_q, dec_q, shift_two);
            round_d = round_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

`ifdef DES_KS_PARITY_CHK_EN
  logic parity_q;
  logic even_byte;

  always_comb begin
    even_byte = 1'b0;
    for (int b = 0; b < 8; b++)
      if (!(^key[8*b +: 8])) even_byte = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       parity_q <= 1'b0;
    else if (load) parity_q <= even_byte;
  end

  assign parity_err = parity_q;
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{load, key[56], key[48], key[40], key[32],
                                key[24], key[16], key[8], key[0]};
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: table vectors, randomized keys with stalls,
// mid-stream reset and back-to-back loads against a cumulative-shift DES reference model.
module tb_des_key_schedule;

  typedef logic [47:0] sk_arr_t [16];

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int M_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] sk_data;
  logic [4:0]  sk_round;
  logic        sk_last;
  logic        parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .decrypt    (decrypt),
    .sk_valid   (sk_valid),
    .sk_ready   (sk_ready),
    .sk_data    (sk_data),
    .sk_round   (sk_round),
    .sk_last    (sk_last),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: Ki = PC2(C0 <<< S_i, D0 <<< S_i) with S_i the cumulative shift count.
  function automatic logic [27:0] m_rotl(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic sk_arr_t model(input logic [63:0] k, input logic dec);
    logic [55:0] cd0, cdi;
    logic [47:0] sk;
    sk_arr_t     enc, res;
    int          total;
    for (int i = 0; i < 56; i++) cd0[55-i] = k[64-M_PC1[i]];
    total = 0;
    for (int r = 0; r < 16; r++) begin
      total = (total + M_SHIFTS[r]) % 28;
      cdi = {m_rotl(cd0[55:28], total), m_rotl(cd0[27:0], total)};
      for (int i = 0; i < 48; i++) sk[47-i] = cdi[56-M_PC2[i]];
      enc[r] = sk;
    end
    for (int r = 0; r < 16; r++) res[r] = dec ? enc[15-r] : enc[r];
    return res;
  endfunction

  function automatic logic model_parity(input logic [63:0] k);
`ifdef DES_KS_PARITY_CHK_EN
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) bad = 1'b1;
    return bad;
`else
    return 1'b0;
`endif
  endfunction

  // Offer a key at a negedge and return at the negedge where K1 should be visible.
  task automatic load_key(input logic [63:0] k, input logic d);
    int waited;
    key_valid = 1'b1;
    key       = k;
    decrypt   = d;
    waited    = 0;
    while (!key_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("key_ready_before_load", key_ready, 1);
    @(negedge clk);
    key_valid = 1'b0;
    key       = $urandom;
    check("first_valid_at_load_plus_1", sk_valid, 1);
    check("first_round_index", sk_round, 1);
    check("parity_err", parity_err, model_parity(k));
  endtask

  // Consume the whole stream; with stall=1 sk_ready and key_valid noise are randomized.
  task automatic drain(input sk_arr_t exp, input bit stall, output sk_arr_t got);
    int          n, cycles;
    bit          prev_stall;
    logic [47:0] prev_data;
    logic [4:0]  prev_round;
    logic        prev_last;
    n = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_round = '0;
    prev_last = 1'b0;
    while (n < 16 && cycles < 400) begin
      if (prev_stall) begin
        check("stall_data_stable", sk_data, prev_data);
        check("stall_round_stable", sk_round, prev_round);
        check("stall_last_stable", sk_last, prev_last);
      end
      check("run_sk_valid", sk_valid, 1);
      check("run_key_ready_low", key_ready, 0);
      sk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        key_valid = 1'($urandom_range(0, 1));
        key       = {$urandom, $urandom};
        decrypt   = 1'($urandom_range(0, 1));
      end
      if (sk_ready) begin
        check("sk_round", sk_round, 64'(n + 1));
        check("sk_last", sk_last, (n == 15) ? 1 : 0);
        check("sk_data", sk_data, exp[n]);
        got[n] = sk_data;
        n++;
      end
      prev_stall = !sk_ready;
      prev_data  = sk_data;
      prev_round = sk_round;
      prev_last  = sk_last;
      @(negedge clk);
      cycles++;
    end
    check("stream_length", 64'(n), 16);
    if (!stall) check("stream_cycles", 64'(cycles), 16);
    sk_ready  = 1'b0;
    key_valid = 1'b0;
    check("idle_sk_valid", sk_valid, 0);
    check("idle_key_ready", key_ready, 1);
    check("idle_sk_data", sk_data, 0);
    check("idle_sk_round", sk_round, 0);
    check("idle_sk_last", sk_last, 0);
  endtask

  initial begin
    vec_t        vecs [4];
    sk_arr_t     exp, got, enc_known, dec_known;
    logic [63:0] k1, k2;
    logic        d;

    vecs[0] = '{key: 64'h133457799BBCDFF1, dec: 1'b0, first: 48'h1B02EFFC7072, last: 48'hCB3D8B0E17F5};
    vecs[1] = '{key: 64'h133457799BBCDFF1, dec: 1'b1, first: 48'hCB3D8B0E17F5, last: 48'h1B02EFFC7072};
    vecs[2] = '{key: 64'h0101010101010101, dec: 1'b0, first: 48'h000000000000, last: 48'h000000000000};
    vecs[3] = '{key: 64'hFEFEFEFEFEFEFEFE, dec: 1'b1, first: 48'hFFFFFFFFFFFF, last: 48'hFFFFFFFFFFFF};

    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    decrypt = 1'b0;
    sk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_key_ready", key_ready, 1);
    check("reset_sk_valid", sk_valid, 0);
    check("reset_sk_data", sk_data, 0);
    check("reset_sk_round", sk_round, 0);
    check("reset_sk_last", sk_last, 0);
    check("reset_parity_err", parity_err, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      load_key(vecs[i].key, vecs[i].dec);
      drain(model(vecs[i].key, vecs[i].dec), 1'b0, got);
      check("vec_first", got[0], vecs[i].first);
      check("vec_last", got[15], vecs[i].last);
      if (i == 0) enc_known = got;
      if (i == 1) dec_known = got;
    end
    for (int r = 0; r < 16; r++) check("decrypt_is_reversed_encrypt", dec_known[r], enc_known[15-r]);
    if (model_parity(64'h133457799BBCDFF1)) begin
      load_key(64'h133457799BBCDFF1, 1'b0);
      drain(model(64'h133457799BBCDFF1, 1'b0), 1'b1, got);
    end

    // Known key with random backpressure and key_valid noise.
    load_key(64'h133457799BBCDFF1, 1'b0);
    drain(enc_known, 1'b1, got);

    // Randomized keys, modes and stall patterns.
    for (int t = 0; t < 12; t++) begin
      k1 = {$urandom, $urandom};
      d  = 1'($urandom_range(0, 1));
      load_key(k1, d);
      drain(model(k1, d), 1'($urandom_range(0, 1)), got);
    end

    // Reset after round 7 accepted, then a fresh load must start cleanly.
    k1 = {$urandom, $urandom};
    load_key(k1, 1'b0);
    exp = model(k1, 1'b0);
    sk_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      check("pre_reset_round", sk_round, 64'(r + 1));
      check("pre_reset_data", sk_data, exp[r]);
      @(negedge clk);
    end
    sk_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_sk_valid", sk_valid, 0);
    check("post_reset_sk_data", sk_data, 0);
    check("post_reset_key_ready", key_ready, 1);
    check("post_reset_sk_round", sk_round, 0);
    check("post_reset_sk_last", sk_last, 0);
    rst = 1'b0;
    @(negedge clk);
    k2 = {$urandom, $urandom};
    load_key(k2, 1'b0);
    drain(model(k2, 1'b0), 1'b0, got);

    // Back-to-back: key_valid held high across the end of the first stream.
    k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    key_valid = 1'b1;
    key = k1;
    decrypt = 1'b1;
    @(negedge clk);
    check("b2b_first_valid", sk_valid, 1);
    key = k2;
    decrypt = 1'b0;
    exp = model(k1, 1'b1);
    begin
      int n;
      n = 0;
      sk_ready = 1'b1;
      while (n < 16) begin
        check("b2b_s1_round", sk_round, 64'(n + 1));
        check("b2b_s1_data", sk_data, exp[n]);
        n++;
        @(negedge clk);
      end
    end
    sk_ready = 1'b0;
    check("b2b_gap_sk_valid", sk_valid, 0);
    check("b2b_gap_key_ready", key_ready, 1);
    @(negedge clk);
    key_valid = 1'b0;
    exp = model(k2, 1'b0);
    check("b2b_k1_valid", sk_valid, 1);
    check("b2b_k1_round", sk_round, 1);
    check("b2b_k1_data", sk_data, exp[0]);
    drain(exp, 1'b0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
